// File: rtl/multi_stopwatch_pkg.sv
// Shared register map, CSR layout and STATUS bit positions for the multi-channel stopwatch.
package multi_stopwatch_pkg;

    localparam logic [2:0] OFF_VALUE       = 3'd0;
    localparam logic [2:0] OFF_RESET_VALUE = 3'd1;
    localparam logic [2:0] OFF_UPPER       = 3'd2;
    localparam logic [2:0] OFF_LOWER       = 3'd3;
    localparam logic [2:0] OFF_CSR         = 3'd4;
    localparam logic [2:0] OFF_STATUS      = 3'd5;

    localparam int unsigned ST_UPPER_HIT = 0;
    localparam int unsigned ST_LOWER_HIT = 1;
    localparam int unsigned ST_WRAPPED   = 2;
    localparam int unsigned ST_CFG_ERR   = 3;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CH_W   = 5;

    typedef struct packed {
        logic       irq_en;
        logic       load;
        logic       mode;
        logic [3:0] stride;
        logic       updown;
        logic       enable;
    } csr_t;

endpackage

// File: rtl/stopwatch_channel.sv
// One stopwatch channel: programmable range/stride counter with sticky status and W1C clear.
module stopwatch_channel
    import multi_stopwatch_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEF_LOWER = 10,
    parameter int unsigned DEF_UPPER = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             wr,
    input  logic [2:0]       offset,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata_c,
    output logic             irq_c
);

    localparam int unsigned XW = WIDTH + 2;

    logic [WIDTH-1:0] value, reset_value, upper, lower, cnt_value;
    csr_t             csr;
    logic [2:0]       status, hw_set, w1c;
    logic             cfg_err;
    logic [XW-1:0]    v_x, up_x, lo_x, s_x, n_up, wrap_up, rhs, diff, wrap_dn;

    assign cfg_err = lower > upper;
    assign v_x     = XW'(value);
    assign up_x    = XW'(upper);
    assign lo_x    = XW'(lower);
    assign s_x     = XW'(csr.stride);
    assign n_up    = v_x + s_x;
    assign wrap_up = lo_x + (n_up - up_x - XW'(1));
    // Down-count compares against lower+stride so the counter never goes below zero.
    assign rhs     = lo_x + s_x;
    assign diff    = rhs - v_x;
    assign wrap_dn = up_x + XW'(1) - diff;

    always_comb begin
        cnt_value = value;
        hw_set    = '0;
        if (tick && !wr && csr.enable && !cfg_err && csr.stride != 4'd0) begin
            if (csr.updown) begin
                if (n_up < up_x) begin
                    cnt_value = WIDTH'(n_up);
                end else if (n_up == up_x) begin
                    cnt_value = WIDTH'(n_up);
                    hw_set[ST_UPPER_HIT] = 1'b1;
                end else if (!csr.mode) begin
                    cnt_value = (wrap_up > up_x) ? lower : WIDTH'(wrap_up);
                    hw_set[ST_WRAPPED] = 1'b1;
                end else begin
                    cnt_value = upper;
                    hw_set[ST_UPPER_HIT] = 1'b1;
                end
            end else begin
                if (v_x > rhs) begin
                    cnt_value = WIDTH'(v_x - s_x);
                end else if (v_x == rhs) begin
                    cnt_value = lower;
                    hw_set[ST_LOWER_HIT] = 1'b1;
                end else if (!csr.mode) begin
                    cnt_value = (up_x + XW'(1) < lo_x + diff) ? upper : WIDTH'(wrap_dn);
                    hw_set[ST_WRAPPED] = 1'b1;
                end else begin
                    cnt_value = lower;
                    hw_set[ST_LOWER_HIT] = 1'b1;
                end
            end
        end
    end

    assign w1c = (wr && offset == OFF_STATUS) ? wdata[2:0] : 3'b000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value       <= WIDTH'(DEF_LOWER);
            reset_value <= WIDTH'(DEF_LOWER);
            lower       <= WIDTH'(DEF_LOWER);
            upper       <= WIDTH'(DEF_UPPER);
            csr         <= '{irq_en: 1'b0, load: 1'b0, mode: 1'b0, stride: 4'd1,
                             updown: 1'b1, enable: 1'b0};
            status      <= '0;
        end else begin
            value  <= cnt_value;
            // Hardware set has priority over a simultaneous W1C clear.
            status <= (status & ~w1c) | hw_set;
            if (wr) begin
                case (offset)
                    OFF_RESET_VALUE: reset_value <= wdata;
                    OFF_UPPER:       upper       <= wdata;
                    OFF_LOWER:       lower       <= wdata;
                    OFF_CSR: begin
                        csr <= csr_t'({wdata[8], 1'b0, wdata[6:0]});
                        if (wdata[7]) begin
                            value <= reset_value;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata_c = '0;
        case (offset)
            OFF_VALUE:       rdata_c = value;
            OFF_RESET_VALUE: rdata_c = reset_value;
            OFF_UPPER:       rdata_c = upper;
            OFF_LOWER:       rdata_c = lower;
            OFF_CSR:         rdata_c = WIDTH'({csr.irq_en, 1'b0, csr.mode, csr.stride,
                                               csr.updown, csr.enable});
            OFF_STATUS:      rdata_c = WIDTH'({cfg_err, status});
            default:         rdata_c = '0;
        endcase
    end

    assign irq_c = csr.irq_en & (|status);

endmodule

// File: rtl/multi_stopwatch.sv
// Multi-channel stopwatch: address decode, registered bus response and combined interrupt.
module multi_stopwatch
    import multi_stopwatch_pkg::*;
#(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEF_LOWER = 10,
    parameter int unsigned DEF_UPPER = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   tick,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rdata,
    output logic              err,
    output logic              irq
);

    logic [CH_W-1:0]  ch;
    logic [2:0]       off;
    logic             ch_ok, acc_err_c, wr_ok_c;
    logic [N_CH-1:0]  ch_wr, ch_irq;
    logic [WIDTH-1:0] ch_rdata [N_CH];
    logic [WIDTH-1:0] sel_rdata_c;

    assign ch        = addr[7:3];
    assign off       = addr[2:0];
    assign ch_ok     = 32'(ch) < N_CH;
    assign acc_err_c = !ch_ok || off > OFF_STATUS || (we && off == OFF_VALUE);
    assign wr_ok_c   = req && we && !acc_err_c;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign ch_wr[g] = wr_ok_c && (ch == CH_W'(g));

        stopwatch_channel #(
            .WIDTH     (WIDTH),
            .DEF_LOWER (DEF_LOWER),
            .DEF_UPPER (DEF_UPPER)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .tick    (tick[g]),
            .wr      (ch_wr[g]),
            .offset  (off),
            .wdata   (wdata),
            .rdata_c (ch_rdata[g]),
            .irq_c   (ch_irq[g])
        );
    end

    always_comb begin
        sel_rdata_c = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch == CH_W'(i)) begin
                sel_rdata_c = ch_rdata[i];
            end
        end
    end

    // Response carries pre-edge register state; writes and errors return zero data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rdata     <= '0;
            err       <= 1'b0;
            irq       <= 1'b0;
        end else begin
            rsp_valid <= req;
            err       <= req && acc_err_c;
            rdata     <= (req && !we && !acc_err_c) ? sel_rdata_c : '0;
            irq       <= |ch_irq;
        end
    end

endmodule

// File: tb/tb_multi_stopwatch.sv
// Self-checking bench for multi_stopwatch: directed vectors plus randomized traffic vs. a behavioural model.
module tb_multi_stopwatch;

    localparam int N = 4;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  tick = '0;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [7:0]    addr = '0;
    logic [W-1:0]  wdata = '0;
    logic          rsp_valid;
    logic [W-1:0]  rdata;
    logic          err;
    logic          irq;

    multi_stopwatch #(.N_CH(N), .WIDTH(W), .DEF_LOWER(10), .DEF_UPPER(14)) dut (
        .clk(clk), .reset(reset), .tick(tick), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .rsp_valid(rsp_valid), .rdata(rdata), .err(err), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    longint m_val [N];
    longint m_rv  [N];
    longint m_up  [N];
    longint m_lo  [N];
    int     m_en  [N];
    int     m_ud  [N];
    int     m_st  [N];
    int     m_md  [N];
    int     m_ie  [N];
    int     m_sts [N];
    bit     e_valid, e_err, e_irq;
    longint e_rdata;

    typedef struct {
        logic [7:0]  addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_val[c] = 10; m_rv[c] = 10; m_lo[c] = 10; m_up[c] = 14;
            m_en[c] = 0; m_ud[c] = 1; m_st[c] = 1; m_md[c] = 0; m_ie[c] = 0; m_sts[c] = 0;
        end
        e_valid = 0; e_err = 0; e_rdata = 0; e_irq = 0;
    endtask

    function automatic longint m_read(input int c, input int o);
        case (o)
            0: return m_val[c];
            1: return m_rv[c];
            2: return m_up[c];
            3: return m_lo[c];
            4: return longint'(m_en[c] + 2 * m_ud[c] + 4 * m_st[c] + 64 * m_md[c] + 256 * m_ie[c]);
            5: return longint'(m_sts[c] + ((m_lo[c] > m_up[c]) ? 8 : 0));
            default: return 0;
        endcase
    endfunction

    // Advance the model by one clock edge given the inputs presented before it.
    task automatic model_step(input bit [N-1:0] t, input bit rq, input bit w,
                              input bit [7:0] a, input bit [31:0] d);
        int c, o, setb;
        bit bad, wr_ok;
        longint n, r;
        c = int'(a) / 8;
        o = int'(a) % 8;
        bad = (c >= N) || (o >= 6) || (w && o == 0);
        wr_ok = rq && w && !bad;
        e_valid = rq;
        e_err = rq && bad;
        e_rdata = (rq && !w && !bad) ? m_read(c, o) : 0;
        e_irq = 0;
        for (int k = 0; k < N; k++) if (m_ie[k] != 0 && m_sts[k] != 0) e_irq = 1;
        for (int k = 0; k < N; k++) begin
            setb = 0;
            if (t[k] && m_en[k] != 0 && !(m_lo[k] > m_up[k]) && !(wr_ok && c == k) && m_st[k] != 0) begin
                if (m_ud[k] != 0) begin
                    n = m_val[k] + m_st[k];
                    if (n < m_up[k]) m_val[k] = n;
                    else if (n == m_up[k]) begin m_val[k] = n; setb = 1; end
                    else if (m_md[k] == 0) begin
                        r = m_lo[k] + (n - m_up[k] - 1);
                        m_val[k] = (r > m_up[k]) ? m_lo[k] : r;
                        setb = 4;
                    end else begin m_val[k] = m_up[k]; setb = 1; end
                end else begin
                    n = m_val[k] - m_st[k];
                    if (n > m_lo[k]) m_val[k] = n;
                    else if (n == m_lo[k]) begin m_val[k] = n; setb = 2; end
                    else if (m_md[k] == 0) begin
                        r = m_up[k] - (m_lo[k] - n - 1);
                        m_val[k] = (r < m_lo[k]) ? m_up[k] : r;
                        setb = 4;
                    end else begin m_val[k] = m_lo[k]; setb = 2; end
                end
            end
            if (wr_ok && c == k && o == 5) m_sts[k] = m_sts[k] & ~int'(d[2:0]);
            m_sts[k] = m_sts[k] | setb;
        end
        if (wr_ok) begin
            case (o)
                1: m_rv[c] = longint'(d);
                2: m_up[c] = longint'(d);
                3: m_lo[c] = longint'(d);
                4: begin
                    m_en[c] = int'(d[0]); m_ud[c] = int'(d[1]); m_st[c] = int'(d[5:2]);
                    m_md[c] = int'(d[6]); m_ie[c] = int'(d[8]);
                    if (d[7]) m_val[c] = m_rv[c];
                end
                default: ;
            endcase
        end
    endtask

    // Called at a negedge: drive, step model, wait one cycle, compare.
    task automatic do_cycle(input bit [N-1:0] t, input bit rq, input bit w,
                            input bit [7:0] a, input bit [31:0] d);
        tick = t; req = rq; we = w; addr = a; wdata = d;
        model_step(t, rq, w, a, d);
        @(negedge clk);
        chk("rsp_valid", longint'(rsp_valid), longint'(e_valid));
        if (e_valid) begin
            chk("rdata", longint'(rdata), e_rdata);
            chk("err", longint'(err), longint'(e_err));
        end
        chk("irq", longint'(irq), longint'(e_irq));
    endtask

    task automatic rd(input bit [7:0] a, input longint exp, input string name);
        do_cycle('0, 1'b1, 1'b0, a, '0);
        chk(name, longint'(rdata), exp);
    endtask

    task automatic wr(input bit [7:0] a, input bit [31:0] d);
        do_cycle('0, 1'b1, 1'b1, a, d);
    endtask

    initial begin
        bit [7:0] ra;
        bit [31:0] rdv;
        model_reset();
        tbl[0] = '{addr: 8'd0,  we: 1'b0, wdata: 32'd0,  exp_rdata: 32'd10, exp_err: 1'b0};
        tbl[1] = '{addr: 8'd2,  we: 1'b0, wdata: 32'd0,  exp_rdata: 32'd14, exp_err: 1'b0};
        tbl[2] = '{addr: 8'd0,  we: 1'b1, wdata: 32'd99, exp_rdata: 32'd0,  exp_err: 1'b1};
        tbl[3] = '{addr: 8'd6,  we: 1'b0, wdata: 32'd0,  exp_rdata: 32'd0,  exp_err: 1'b1};
        tbl[4] = '{addr: 8'd32, we: 1'b0, wdata: 32'd0,  exp_rdata: 32'd0,  exp_err: 1'b1};
        tbl[5] = '{addr: 8'd34, we: 1'b1, wdata: 32'd5,  exp_rdata: 32'd0,  exp_err: 1'b1};
        tbl[6] = '{addr: 8'd0,  we: 1'b0, wdata: 32'd0,  exp_rdata: 32'd10, exp_err: 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", longint'(rsp_valid), 0);
        chk("reset_rdata", longint'(rdata), 0);
        chk("reset_err", longint'(err), 0);
        chk("reset_irq", longint'(irq), 0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do_cycle('0, 1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            chk($sformatf("tbl%0d_rdata", i), longint'(rdata), longint'(tbl[i].exp_rdata));
            chk($sformatf("tbl%0d_err", i), longint'(err), longint'(tbl[i].exp_err));
        end

        // ch1: up, stride 3, wrap
        wr(8'd12, 32'h00F);
        do_cycle(4'b0010, 1'b0, 1'b0, '0, '0);
        rd(8'd8, 13, "ch1_val_13");
        do_cycle(4'b0010, 1'b0, 1'b0, '0, '0);
        rd(8'd8, 11, "ch1_val_wrap_11");
        rd(8'd13, 4, "ch1_status_wrapped");
        wr(8'd13, 32'd4);
        rd(8'd13, 0, "ch1_status_cleared");

        // ch2: down, stride 4, saturate, irq_en
        wr(8'd20, 32'h151);
        do_cycle(4'b0100, 1'b0, 1'b0, '0, '0);
        chk("ch2_irq_not_yet", longint'(irq), 0);
        do_cycle('0, 1'b0, 1'b0, '0, '0);
        chk("ch2_irq_set", longint'(irq), 1);
        rd(8'd16, 10, "ch2_val_sat");
        rd(8'd21, 2, "ch2_lower_hit");
        wr(8'd21, 32'd7);
        do_cycle('0, 1'b0, 1'b0, '0, '0);
        do_cycle('0, 1'b0, 1'b0, '0, '0);
        chk("ch2_irq_cleared", longint'(irq), 0);

        // ch3: cfg_err blocks counting, bus write suppresses tick
        wr(8'd27, 32'd20);
        wr(8'd28, 32'h007);
        do_cycle(4'b1000, 1'b0, 1'b0, '0, '0);
        rd(8'd24, 10, "ch3_cfgerr_hold");
        rd(8'd29, 8, "ch3_cfg_err");
        wr(8'd27, 32'd10);
        do_cycle(4'b1000, 1'b1, 1'b1, 8'd25, 32'd10);
        rd(8'd24, 10, "ch3_wr_suppress");
        do_cycle(4'b1000, 1'b0, 1'b0, '0, '0);
        rd(8'd24, 11, "ch3_count_11");

        // Access in flight when reset asserts gives no response
        tick = '0; req = 1'b1; we = 1'b0; addr = 8'd0; wdata = '0;
        @(posedge clk);
        #1 reset = 1'b1;
        req = 1'b0;
        @(negedge clk);
        chk("inflight_no_rsp", longint'(rsp_valid), 0);
        chk("inflight_irq", longint'(irq), 0);
        reset = 1'b0;
        model_reset();
        rd(8'd8, 10, "post_reset_ch1_val");

        for (int i = 0; i < 3000; i++) begin
            ra = 8'($urandom_range(0, 8 * (N + 1) - 1));
            if ($urandom_range(0, 99) == 0) ra = 8'($urandom_range(0, 255));
            case (ra[2:0])
                3'd4:    rdv = 32'($urandom_range(0, 511));
                3'd5:    rdv = 32'($urandom_range(0, 7));
                default: rdv = 32'($urandom_range(0, 40));
            endcase
            do_cycle(N'($urandom), 1'($urandom), 1'($urandom), ra, rdv);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/multi_stopwatch.md
MULTI_STOPWATCH -- requirements
Module: multi_stopwatch

Interface
REQ-001 Parameter: N_CH, default 4, number of independent counter channels (1..16).
REQ-002 Parameter: WIDTH, default 32, counter and data width (8..32).
REQ-003 Parameter: DEF_LOWER, default 10, reset value of LOWER, RESET_VALUE and VALUE.
REQ-004 Parameter: DEF_UPPER, default 14, reset value of UPPER.
REQ-005 Port: clk  in  1  clock; all state updates on posedge.
REQ-006 Port: reset  in  1  asynchronous, active-high reset.
REQ-007 Port: tick  in  N_CH  per-channel count strobe, sampled each clk.
REQ-008 Port: req  in  1  bus access request; accepted every cycle, no backpressure.
REQ-009 Port: we  in  1  1 = write, 0 = read; qualified by req.
REQ-010 Port: addr  in  8  word address; channel = addr[7:3], offset = addr[2:0].
REQ-011 Port: wdata  in  WIDTH  write data.
REQ-012 Port: rsp_valid  out  1  pulses exactly one cycle after every accepted req.
REQ-013 Port: rdata  out  WIDTH  read data, valid with rsp_valid; 0 for writes and errors.
REQ-014 Port: err  out  1  access error, valid with rsp_valid.
REQ-015 Port: irq  out  1  level interrupt, registered.

Function
REQ-016 Each channel SHALL map, by offset: 0 VALUE (RO), 1 RESET_VALUE, 2 UPPER, 3 LOWER, 4 CSR, 5 STATUS (W1C), 6-7 reserved.
REQ-017 CSR SHALL be: [0] enable, [1] updown (1 = up), [5:2] stride, [6] mode (0 = wrap, 1 = saturate), [7] load (write-only, reads 0), [8] irq_en; other bits read 0.
REQ-018 STATUS SHALL be: [0] upper_hit, [1] lower_hit, [2] wrapped, all sticky and write-1-to-clear; [3] cfg_err, read-only, level = (LOWER > UPPER).
REQ-019 Each of the following SHALL set err = 1: a write to VALUE, any access to a reserved offset, and any access with channel >= N_CH; an erroring write SHALL change no state.
REQ-020 A write of load = 1 SHALL set VALUE to RESET_VALUE on the same edge; the remaining CSR fields SHALL update from wdata.
REQ-021 A channel SHALL count when tick[c] = 1, enable = 1 and cfg_err = 0; otherwise VALUE SHALL hold.
REQ-022 Up-count SHALL compute n = VALUE + stride in WIDTH+1 bits.
REQ-023 Up-count, n == UPPER: VALUE = n and upper_hit SHALL be set.
REQ-024 Up-count, n > UPPER, wrap mode: VALUE = LOWER + (n - UPPER - 1), forced to LOWER if the result exceeds UPPER; wrapped SHALL be set.
REQ-025 Up-count, n > UPPER, saturate mode: VALUE = UPPER and upper_hit SHALL be set.
REQ-026 Down-count SHALL mirror REQ-022..025 about LOWER, using lower_hit, computed without underflow.
REQ-027 stride = 0 SHALL leave VALUE unchanged and set no status bits.
REQ-028 A bus write to any register of channel c SHALL suppress tick[c] in that cycle.
REQ-029 When a hardware set and a W1C clear hit the same STATUS bit in one cycle, the set SHALL win.
REQ-030 irq SHALL be the registered OR over all channels of (irq_en AND (upper_hit OR lower_hit OR wrapped)), one cycle after the status change.
REQ-031 Read latency SHALL be 1 cycle; rdata SHALL reflect register state before the edge on which req was sampled.

Reset
REQ-032 On reset: VALUE = RESET_VALUE = LOWER = DEF_LOWER; UPPER = DEF_UPPER; CSR = enable 0, updown 1, stride 1, mode 0, irq_en 0; STATUS = 0.
REQ-033 On reset: rsp_valid = 0, rdata = 0, err = 0, irq = 0.
REQ-034 An access in flight at reset SHALL produce no response.

Structure
REQ-035 Package multi_stopwatch_pkg SHALL hold the offset constants, the CSR packed struct and the STATUS bit indices.
REQ-036 Sub-module stopwatch_channel SHALL implement one channel (registers plus count logic); the top SHALL instantiate N_CH copies and hold the address decode, response register and irq.

Verification
REQ-037 After reset, read ch0 offset 0 -> rdata 10, err 0; read ch0 offset 2 -> rdata 14.
REQ-038 ch1: CSR = enable, up, stride 3, wrap; 2 ticks from 10 -> VALUE 13 then 11; wrapped = 1; write STATUS 4 -> reads 0.
REQ-039 ch2: saturate, down, stride 4; 1 tick from 10 -> VALUE 10, lower_hit = 1; with irq_en = 1 -> irq = 1 one cycle after the status set.
REQ-040 Write offset 0, read offset 6, and access channel N_CH -> err = 1 each, rdata 0, no state change.
REQ-041 Set LOWER = 20 > UPPER = 14, then tick -> VALUE holds and cfg_err = 1; write in the same cycle as tick[3] to ch3 -> no count.
